// File: rtl/reg_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_access_ctrl                                              |
// | Description : Multicycle register-file initiator (IDLE/READ/EXEC/WRITE).    |
// |               Optional status flags are enabled with the FLAGS_EN macro.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_access_ctrl #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2,
  parameter int WADDR_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [RADDR_W-1:0] RegLido1,
  output logic [RADDR_W-1:0] RegLido2,
  input  logic [DATA_W-1:0]  Dado1,
  input  logic [DATA_W-1:0]  Dado2,
  output logic [WADDR_W-1:0] RegEsc,
  output logic               EscReg,
  output logic [DATA_W-1:0]  DadoEscr,
`ifdef FLAGS_EN
  output logic               zero_flag,
  output logic               carry_flag,
`endif
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  state_t              state_q, state_d;
  logic [7:0]          instr_q;
  logic [RADDR_W-1:0]  rlido1_q, rlido2_q;
  logic [WADDR_W-1:0]  resc_q;
  logic                escreg_q;
  logic                done_q;
  logic [DATA_W-1:0]   dado_q;

  logic                accept;
  logic [DATA_W:0]     sum_ext;
  logic [DATA_W:0]     diff_ext;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;

  assign instr_ready = (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Extended-width add/sub expose carry-out and borrow in the top bit.
  assign sum_ext  = {1'b0, Dado1} + {1'b0, Dado2};
  assign diff_ext = {1'b0, Dado1} - {1'b0, Dado2};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (instr_q[7:6])
      OP_ADD: begin
        alu_res   = sum_ext[DATA_W-1:0];
        alu_carry = sum_ext[DATA_W];
      end
      OP_SUB: begin
        alu_res   = diff_ext[DATA_W-1:0];
        alu_carry = diff_ext[DATA_W];
      end
      OP_AND:  alu_res = Dado1 & Dado2;
      default: alu_res = DATA_W'(instr_q[3:0]);
    endcase
  end

  // Read addresses load on the accept edge so they are stable through READ and EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q  <= '0;
      rlido1_q <= '0;
      rlido2_q <= '0;
      resc_q   <= '0;
      escreg_q <= 1'b0;
      done_q   <= 1'b0;
      dado_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            instr_q  <= instr;
            rlido1_q <= RADDR_W'(instr[3:2]);
            rlido2_q <= RADDR_W'(instr[1:0]);
          end
        end
        S_EXEC: begin
          dado_q   <= alu_res;
          resc_q   <= WADDR_W'(instr_q[5:4]);
          escreg_q <= 1'b1;
          done_q   <= 1'b1;
        end
        S_WRITE: begin
          escreg_q <= 1'b0;
          done_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FLAGS_EN
  logic carry_pend_q;
  logic zero_flag_q;
  logic carry_flag_q;

  // Flags commit only at the end of WRITE so an aborted instruction leaves them untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_pend_q <= 1'b0;
      zero_flag_q  <= 1'b0;
      carry_flag_q <= 1'b0;
    end else begin
      if (state_q == S_EXEC) carry_pend_q <= alu_carry;
      if (state_q == S_WRITE) begin
        zero_flag_q  <= (dado_q == '0);
        carry_flag_q <= carry_pend_q;
      end
    end
  end

  assign zero_flag  = zero_flag_q;
  assign carry_flag = carry_flag_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

  assign RegLido1 = rlido1_q;
  assign RegLido2 = rlido2_q;
  assign RegEsc   = resc_q;
  assign EscReg   = escreg_q;
  assign DadoEscr = dado_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_access_ctrl                                           |
// | Description : Directed, table-driven bench for reg_access_ctrl.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reg_access_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [1:0] RegLido1, RegLido2;
  logic [7:0] Dado1 = 8'h00;
  logic [7:0] Dado2 = 8'h00;
  logic [2:0] RegEsc;
  logic       EscReg;
  logic [7:0] DadoEscr;
  logic       done;

  int errors = 0;
  int checks = 0;

  reg_access_ctrl #(.DATA_W(8), .RADDR_W(2), .WADDR_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .RegLido1    (RegLido1),
    .RegLido2    (RegLido2),
    .Dado1       (Dado1),
    .Dado2       (Dado2),
    .RegEsc      (RegEsc),
    .EscReg      (EscReg),
    .DadoEscr    (DadoEscr),
    .done        (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] ins;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] rl1;
    logic [1:0] rl2;
    logic [2:0] resc;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction through all four states, checking each cycle.
  task automatic run_vec(input vec_t v);
    @(negedge clock);
    chk("idle_ready", {31'd0, instr_ready}, 32'd1);
    instr       = v.ins;
    instr_valid = 1'b1;
    Dado1       = v.d1;
    Dado2       = v.d2;
    @(negedge clock);
    instr_valid = 1'b0;
    instr       = 8'h5A;
    chk("read_ready", {31'd0, instr_ready}, 32'd0);
    chk("read_rl1", {30'd0, RegLido1}, {30'd0, v.rl1});
    chk("read_rl2", {30'd0, RegLido2}, {30'd0, v.rl2});
    chk("read_esc", {31'd0, EscReg}, 32'd0);
    @(negedge clock);
    chk("exec_rl1", {30'd0, RegLido1}, {30'd0, v.rl1});
    chk("exec_rl2", {30'd0, RegLido2}, {30'd0, v.rl2});
    chk("exec_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    chk("write_esc", {31'd0, EscReg}, 32'd1);
    chk("write_done", {31'd0, done}, 32'd1);
    chk("write_ready", {31'd0, instr_ready}, 32'd0);
    chk("write_resc", {29'd0, RegEsc}, {29'd0, v.resc});
    chk("write_data", {24'd0, DadoEscr}, {24'd0, v.res});
    Dado1 = 8'hC3;
    Dado2 = 8'h3C;
    @(negedge clock);
    chk("after_esc", {31'd0, EscReg}, 32'd0);
    chk("after_done", {31'd0, done}, 32'd0);
    chk("after_ready", {31'd0, instr_ready}, 32'd1);
    chk("after_hold", {24'd0, DadoEscr}, {24'd0, v.res});
  endtask

  initial begin
    vecs[0] = '{8'b00_10_01_10, 8'h05, 8'h03, 2'd1, 2'd2, 3'b010, 8'h08};
    vecs[1] = '{8'b01_01_00_11, 8'h00, 8'h01, 2'd0, 2'd3, 3'b001, 8'hFF};
    vecs[2] = '{8'b11_11_1010,  8'h77, 8'h99, 2'd2, 2'd2, 3'b011, 8'h0A};
    vecs[3] = '{8'b10_00_11_01, 8'hF0, 8'h0F, 2'd3, 2'd1, 3'b000, 8'h00};
    vecs[4] = '{8'b00_11_10_00, 8'hFF, 8'h02, 2'd2, 2'd0, 3'b011, 8'h01};
    vecs[5] = '{8'b01_00_01_10, 8'h10, 8'h03, 2'd1, 2'd2, 3'b000, 8'h0D};
    vecs[6] = '{8'b10_01_10_11, 8'hAC, 8'h3C, 2'd2, 2'd3, 3'b001, 8'h2C};
    vecs[7] = '{8'b11_00_0000,  8'h55, 8'hAA, 2'd0, 2'd0, 3'b000, 8'h00};

    // Reset state
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_esc", {31'd0, EscReg}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rl", {28'd0, RegLido1, RegLido2}, 32'd0);
    chk("rst_resc", {29'd0, RegEsc}, 32'd0);
    chk("rst_data", {24'd0, DadoEscr}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back with valid held high; live bus changes must not affect the captured instr.
    @(negedge clock);
    instr       = 8'b00_01_10_11;
    instr_valid = 1'b1;
    Dado1       = 8'h11;
    Dado2       = 8'h22;
    @(negedge clock);
    instr = 8'b11_10_0101;
    chk("b2b_read_ready", {31'd0, instr_ready}, 32'd0);
    chk("b2b_read_rl", {28'd0, RegLido1, RegLido2}, {28'd0, 2'd2, 2'd3});
    @(negedge clock);
    chk("b2b_exec_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clock);
    chk("b2b_w1_esc", {31'd0, EscReg}, 32'd1);
    chk("b2b_w1_resc", {29'd0, RegEsc}, 32'd1);
    chk("b2b_w1_data", {24'd0, DadoEscr}, 32'h33);
    @(negedge clock);
    chk("b2b_idle_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clock);
    instr_valid = 1'b0;
    chk("b2b2_read_rl", {28'd0, RegLido1, RegLido2}, {28'd0, 2'd1, 2'd1});
    chk("b2b2_read_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("b2b_w2_esc", {31'd0, EscReg}, 32'd1);
    chk("b2b_w2_resc", {29'd0, RegEsc}, 32'd2);
    chk("b2b_w2_data", {24'd0, DadoEscr}, 32'h05);
    @(negedge clock);
    chk("b2b_end_ready", {31'd0, instr_ready}, 32'd1);

    // Reset mid-EXEC aborts with no write.
    instr       = 8'b00_11_01_01;
    instr_valid = 1'b1;
    Dado1       = 8'h01;
    Dado2       = 8'h01;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rexec_ready", {31'd0, instr_ready}, 32'd1);
    chk("rexec_esc", {31'd0, EscReg}, 32'd0);
    chk("rexec_rl", {28'd0, RegLido1, RegLido2}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("rexec_nowrite", {31'd0, EscReg}, 32'd0);
      chk("rexec_nodone", {31'd0, done}, 32'd0);
    end

    // Reset mid-WRITE drops EscReg asynchronously.
    instr       = 8'b00_10_00_01;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rwr_esc_pre", {31'd0, EscReg}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rwr_esc", {31'd0, EscReg}, 32'd0);
    chk("rwr_done", {31'd0, done}, 32'd0);
    chk("rwr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rwr_data", {24'd0, DadoEscr}, 32'd0);
    chk("rwr_resc", {29'd0, RegEsc}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rwr_idle", {31'd0, instr_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
